// File: rtl/mem_stage_pkg.sv
// Shared myCPU header for the memory stage: bus widths, field codes and the
// execute-to-memory payload layout.
package mem_stage_pkg;

    localparam int EXE_TO_MEM_BUS_WD = 78;
    localparam int MEM_TO_WB_BUS_WD  = 38;
    localparam int MEM_TO_BY_BUS_WD  = 39;

    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_PC8  = 2'b01;
    localparam logic [1:0] SEL_LOAD = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    typedef struct packed {
        logic [1:0]  sel_rf_w_data;
        logic        sel_rf_w_en;
        logic        sel_mem_gene;
        logic [2:0]  load_type;
        logic [1:0]  addr_low;
        logic [31:0] pc_plus_8;
        logic [31:0] exe_w_data;
        logic [4:0]  rf_w_addr;
    } exe_to_mem_t;

    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Sub-word load alignment: picks the addressed byte/half-word from the read
// word and sign- or zero-extends it to 32 bits.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  load_type_i,
    input  logic [1:0]  addr_low_i,
    output logic [31:0] ext_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Byte/half-word lane select followed by extension per load type
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        ext_o  = word_i;
        case (addr_low_i)
            2'b00:   byte_s = word_i[7:0];
            2'b01:   byte_s = word_i[15:8];
            2'b10:   byte_s = word_i[23:16];
            2'b11:   byte_s = word_i[31:24];
            default: byte_s = 8'h00;
        endcase
        // addr_low[0] is deliberately ignored for half-word loads
        if (addr_low_i[1]) begin
            half_s = word_i[31:16];
        end else begin
            half_s = word_i[15:0];
        end
        case (load_type_i)
            LT_LB:   ext_o = sext8(byte_s);
            LT_LBU:  ext_o = {24'h000000, byte_s};
            LT_LH:   ext_o = sext16(half_s);
            LT_LHU:  ext_o = {16'h0000, half_s};
            default: ext_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: registers the execute bundle, aligns synchronous
// RAM load data (with a hold buffer for back-pressure) and drives WB/bypass.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic [EXE_TO_MEM_BUS_WD-1:0] EXE_to_MEM_bus,
    input  logic                         EXE_to_MEM_valid,
    output logic                         MEM_allow_in,
    input  logic [31:0]                  data_ram_r_data,
    output logic                         MEM_to_WB_valid,
    input  logic                         WB_allow_in,
    output logic [MEM_TO_WB_BUS_WD-1:0]  MEM_to_WB_bus,
    output logic [MEM_TO_BY_BUS_WD-1:0]  MEM_to_BY_bus
);

    logic        mem_valid_q;
    logic        mem_valid_d;
    exe_to_mem_t payload_q;
    exe_to_mem_t payload_d;
    logic        first_cycle_q;
    logic        first_cycle_d;
    logic [31:0] rdata_hold_q;
    logic [31:0] rdata_hold_d;

    logic        accept_s;
    logic [31:0] rdata_s;
    logic [31:0] load_val_s;
    logic [31:0] rf_w_data_s;
    logic        unused_mem_gene_s;

    // Ready-go is always 1, so the stage frees whenever WB takes the current one
    assign MEM_allow_in      = ~mem_valid_q | WB_allow_in;
    assign accept_s          = MEM_allow_in & EXE_to_MEM_valid;
    assign MEM_to_WB_valid   = mem_valid_q;
    assign unused_mem_gene_s = payload_q.sel_mem_gene;

    // Next-state for valid, payload and the load-data hold buffer
    always_comb begin
        mem_valid_d   = mem_valid_q;
        payload_d     = payload_q;
        first_cycle_d = accept_s;
        rdata_hold_d  = rdata_hold_q;
        if (MEM_allow_in) begin
            mem_valid_d = EXE_to_MEM_valid;
        end else begin
            mem_valid_d = mem_valid_q;
        end
        if (accept_s) begin
            payload_d = exe_to_mem_t'(EXE_to_MEM_bus);
        end else begin
            payload_d = payload_q;
        end
        if (first_cycle_q) begin
            rdata_hold_d = data_ram_r_data;
        end else begin
            rdata_hold_d = rdata_hold_q;
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid_q   <= 1'b0;
            payload_q     <= exe_to_mem_t'({EXE_TO_MEM_BUS_WD{1'b0}});
            first_cycle_q <= 1'b0;
            rdata_hold_q  <= 32'h0000_0000;
        end else begin
            mem_valid_q   <= mem_valid_d;
            payload_q     <= payload_d;
            first_cycle_q <= first_cycle_d;
            rdata_hold_q  <= rdata_hold_d;
        end
    end

    // RAM data is only live in the cycle right after acceptance
    assign rdata_s = first_cycle_q ? data_ram_r_data : rdata_hold_q;

    load_align u_load_align (
        .word_i      (rdata_s),
        .load_type_i (payload_q.load_type),
        .addr_low_i  (payload_q.addr_low),
        .ext_o       (load_val_s)
    );

    // Final register-file write value select
    always_comb begin
        rf_w_data_s = 32'h0000_0000;
        case (payload_q.sel_rf_w_data)
            SEL_ALU:  rf_w_data_s = payload_q.exe_w_data;
            SEL_PC8:  rf_w_data_s = payload_q.pc_plus_8;
            SEL_LOAD: rf_w_data_s = load_val_s;
            SEL_ZERO: rf_w_data_s = 32'h0000_0000;
            default:  rf_w_data_s = 32'h0000_0000;
        endcase
    end

    assign MEM_to_WB_bus = {payload_q.sel_rf_w_en, payload_q.rf_w_addr, rf_w_data_s};
    assign MEM_to_BY_bus = {payload_q.sel_rf_w_en, mem_valid_q, payload_q.rf_w_addr, rf_w_data_s};

endmodule

// File: doc/mem_stage.md
# mem_stage

Fourth pipeline stage of the five-stage in-order MIPS core. It sits between the execute stage and the write-back stage. It registers the execute-stage result bundle and takes the synchronous data-RAM read data issued the previous cycle. It sign- or zero-extends sub-word loads, selects the final register-file write value, and drives write-back and bypass buses. A hold buffer keeps load data correct across write-back back-pressure.

## Interface
Parameters: none. All widths come from the shared header constants `EXE_TO_MEM_BUS_WD` (78), `MEM_TO_WB_BUS_WD` (38) and `MEM_TO_BY_BUS_WD` (39).

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset. Synchronous, active-high.
- `EXE_to_MEM_bus` in 78: input bundle, fields listed under Operation.
- `EXE_to_MEM_valid` in 1: upstream holds a valid instruction.
- `MEM_allow_in` out 1: this stage accepts an instruction this cycle.
- `data_ram_r_data` in 32: synchronous RAM read data. Valid the cycle after the execute stage presented the address.
- `MEM_to_WB_valid` out 1: `MEM_to_WB_bus` carries a valid instruction.
- `WB_allow_in` in 1: write-back stage accepts this cycle.
- `MEM_to_WB_bus` out 38: {rf_w_en[37], rf_w_addr[36:32], rf_w_data[31:0]}.
- `MEM_to_BY_bus` out 39: {rf_w_en[38], mem_valid[37], rf_w_addr[36:32], rf_w_data[31:0]}. Consumed by the decode-stage bypass network.

## Operation
Input bundle fields (MSB first):
- `sel_rf_w_data`[77:76]: 00 = ALU result, 01 = PC+8, 10 = load data, 11 = reserved, forces the write data to 0.
- `sel_rf_w_en`[75].
- `sel_mem_gene`[74]: 1 for a load.
- `load_type`[73:71]: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU. Codes 101–111 are treated as LW.
- `addr_low`[70:69]: bits [1:0] of the data address.
- `pc_plus_8`[68:37].
- `exe_w_data`[36:5]: ALU result, or PC+8 already selected upstream.
- `rf_w_addr`[4:0].

Pipeline control:
- `mem_valid` register. On reset it clears to 0. When `MEM_allow_in`=1 it loads `EXE_to_MEM_valid`. Otherwise it holds.
- `MEM_ready_go` is constant 1.
- `MEM_to_WB_valid` = `mem_valid`.
- `MEM_allow_in` = ~`mem_valid` | `WB_allow_in`.
- The payload register loads `EXE_to_MEM_bus` only when `MEM_allow_in` & `EXE_to_MEM_valid`. Otherwise it holds. Reset clears it to all-zero.

Load-data hold buffer:
- `first_cycle` register. Next value is (`MEM_allow_in` & `EXE_to_MEM_valid`). Reset clears it to 0.
- `rdata_hold` register, 32 bits. Captures `data_ram_r_data` when `first_cycle`=1. Otherwise it holds. Reset clears it to 0.
- Effective read word = `first_cycle` ? `data_ram_r_data` : `rdata_hold`.

Load alignment:
- LB / LBU select byte `addr_low`: 0 → [7:0], 1 → [15:8], 2 → [23:16], 3 → [31:24]. LB sign-extends, LBU zero-extends.
- LH / LHU select the half-word by `addr_low[1]`: 0 → [15:0], 1 → [31:16]. `addr_low[0]` is ignored; a misaligned access raises no exception in this version.
- LW passes the word unchanged.

Outputs:
- `rf_w_data` is selected per `sel_rf_w_data` from `exe_w_data`, `pc_plus_8`, the aligned load value, or 0.
- Both output buses are driven from the payload register plus this datapath.
- The bypass bus always carries final data, including load data. Load-use stalls are therefore not generated here.

## Timing
- Latency: one cycle from acceptance to `MEM_to_WB_valid`. There are no internal wait states.
- Reset values: `MEM_to_WB_valid`=0, `MEM_allow_in`=1, `MEM_to_WB_bus`=0, `MEM_to_BY_bus`=0.
- Sustained throughput is one instruction per cycle while `WB_allow_in`=1.
- Stall: if `WB_allow_in`=0 while `mem_valid`=1, all outputs hold stable. From the second stalled cycle on, the load value comes from `rdata_hold`, independent of `data_ram_r_data` changes.
- Simultaneous drain and accept in the same cycle is legal: the new bundle replaces the old one, and `first_cycle` is set again.
- Bubble: if `EXE_to_MEM_valid`=0 when `MEM_allow_in`=1, then `mem_valid` becomes 0. Payload contents are then don't-care, and the bypass valid bit is 0.
- Reset in mid-stall discards the held instruction on the next edge.

## Structure
- Bus widths, `load_type` codes and `sel_rf_w_data` codes go in the shared myCPU header.
- One combinational sub-module, `load_align`. Inputs: 32-bit word, `load_type`, `addr_low`. Output: 32-bit extended value.

## Test plan
- Back-to-back ALU ops, `WB_allow_in`=1: rf_w_data 0x12345678 enters at cycle n and is on `MEM_to_WB_bus` at n+1 with valid=1. The next op follows at n+2.
- LB, `addr_low`=2, RAM word 0x0080FF11 → 0xFFFFFF80. LBU, same inputs → 0x00000080.
- LH, `addr_low`=2, word 0x8001_7FFF → 0xFFFF8001. LHU → 0x00008001. LH, `addr_low`=0 → 0x00007FFF.
- LW with `WB_allow_in`=0 for 3 cycles while `data_ram_r_data` changes each cycle: output holds the first-cycle word 0xDEADBEEF throughout, and `MEM_allow_in`=0 throughout.
- JAL-type instruction with `sel_rf_w_data`=01 and `pc_plus_8`=0xBFC00010: write data is 0xBFC00010 and rf_w_addr is 31.
- Reset asserted during a stalled load: next cycle `MEM_to_WB_valid`=0, `MEM_allow_in`=1, both buses 0.
